// File: rtl/baseline_ctrl.sv
// baseline_ctrl: sequences the drift histogram and tracks the ADC baseline from its peak bin
module baseline_ctrl #(
  parameter int ACC_CYCLES    = 65536,
  parameter int SETTLE_CYCLES = 516,
  parameter int RD_LAT        = 2,
  parameter int MIN_PEAK      = 16,
  parameter int LOCK_TOL      = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [13:0] init_center,
  input  logic [13:0] q_b,
  output logic [13:0] center_val,
  output logic        pause,
  output logic        rescale,
  output logic [8:0]  rdaddr,
  output logic [8:0]  peak_bin,
  output logic [13:0] peak_count,
  output logic        update,
  output logic        low_stat,
  output logic        locked
);
  typedef enum logic [2:0] {IDLE, SETTLE, ACCUM, FREEZE, SCAN, DECIDE} state_t;
  state_t state, state_n;
  logic [31:0] cnt;
  logic [8:0] max_bin, bin, cand_bin, abs_delta;
  logic [13:0] max_cnt, cand_cnt, sat;
  logic signed [15:0] sum;
  logic sampling, take, low, same;
  // scan running-max candidate and the saturated re-centre value
  always_comb begin
    bin = cnt[8:0] - 9'(RD_LAT);
    sampling = state == SCAN && cnt >= 32'(RD_LAT);
    take = cnt == 32'(RD_LAT) || q_b > max_cnt;
    cand_bin = take ? bin : max_bin;
    cand_cnt = take ? q_b : max_cnt;
    sum = $signed({2'b0, center_val}) + $signed({7'b0, peak_bin}) - 16'sd255;
    sat = sum < 16'sd0 ? 14'd0 : sum > 16'sd16383 ? 14'h3fff : sum[13:0];
    abs_delta = peak_bin >= 9'd255 ? peak_bin - 9'd255 : 9'd255 - peak_bin;
    low = peak_count < 14'(MIN_PEAK);
    same = sat == center_val;
  end
  // next-state: enable low from any active state returns to IDLE
  always_comb begin
    state_n = state;
    if (state != IDLE && !enable) state_n = IDLE;
    else
      case (state)
        IDLE:    state_n = enable ? SETTLE : IDLE;
        SETTLE:  state_n = cnt == 32'(SETTLE_CYCLES - 1) ? ACCUM : SETTLE;
        ACCUM:   state_n = cnt == 32'(ACC_CYCLES - 1) ? FREEZE : ACCUM;
        FREEZE:  state_n = cnt == 32'd1 ? SCAN : FREEZE;
        SCAN:    state_n = cnt == 32'(511 + RD_LAT) ? DECIDE : SCAN;
        DECIDE:  state_n = (low || same) ? ACCUM : SETTLE;
        default: state_n = IDLE;
      endcase
  end
  // state register and per-state cycle counter, cleared on every transition
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= (state_n != state || state == IDLE) ? '0 : cnt + 32'd1;
    end
  // registered outputs: histogram controls, scan maximum, and the baseline decision
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      center_val <= '0;
      pause <= 1'b0;
      rescale <= 1'b0;
      rdaddr <= '0;
      peak_bin <= '0;
      peak_count <= '0;
      update <= 1'b0;
      low_stat <= 1'b0;
      locked <= 1'b0;
      max_bin <= '0;
      max_cnt <= '0;
    end else begin
      pause <= state_n == FREEZE || state_n == SCAN;
      rescale <= state_n == ACCUM;
      update <= 1'b0;
      low_stat <= 1'b0;
      if (state == IDLE && enable) center_val <= init_center;
      if (state_n == FREEZE) rdaddr <= '0;
      else if (state == SCAN && enable && rdaddr != 9'd511) rdaddr <= rdaddr + 9'd1;
      if (sampling && enable) begin
        max_bin <= cand_bin;
        max_cnt <= cand_cnt;
      end
      if (state == SCAN && state_n == DECIDE) begin
        peak_bin <= cand_bin;
        peak_count <= cand_cnt;
      end
      if (state == DECIDE && enable) begin
        if (low) low_stat <= 1'b1;
        else if (same) locked <= 1'b1;
        else begin
          center_val <= sat;
          update <= 1'b1;
          locked <= (abs_delta <= 9'(LOCK_TOL));
        end
      end
    end
endmodule
